// File: rtl/instr_mem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Optional CHK state exists only when LOADER_CHECKSUM_EN is defined.
package instr_mem_loader_pkg;

   localparam int HDR_BYTES  = 2;
   localparam int WORD_BYTES = 4;
   localparam int LEN_W      = 8 * HDR_BYTES;

   typedef enum logic [2:0] {
      IDLE,
      LEN_HI,
      LEN_LO,
      DATA,
`ifdef LOADER_CHECKSUM_EN
      CHK,
`endif
      DONE,
      ERR
   } loader_state_e;

endpackage

// File: rtl/instr_mem_loader_if.sv
// Byte-stream input and IM write port of the loader, bundled as one interface.
// master = host side / memory observer, slave = loader.
interface instr_mem_loader_if #(
   parameter int ADDR_W = 10
);
   logic [7:0]        in_data_i;
   logic              in_valid_i;
   logic              in_ready_o;
   logic              imem_we_o;
   logic [ADDR_W-1:0] imem_addr_o;
   logic [31:0]       imem_data_o;

   modport master (
      output in_data_i, in_valid_i,
      input  in_ready_o, imem_we_o, imem_addr_o, imem_data_o
   );

   modport slave (
      input  in_data_i, in_valid_i,
      output in_ready_o, imem_we_o, imem_addr_o, imem_data_o
   );
endinterface

// File: rtl/instr_mem_loader_byte_packer.sv
// 8->32 big-endian word assembler: first byte lands in word[31:24].
// word/word_valid are combinational on the transfer of the final byte.
module byte_packer
   import instr_mem_loader_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clear,
   input  logic [7:0]              data,
   input  logic                    valid,
   output logic [8*WORD_BYTES-1:0] word,
   output logic                    word_valid
);

   localparam int CNT_W = $clog2(WORD_BYTES);

   logic [8*(WORD_BYTES-1)-1:0] shift_q;
   logic [CNT_W-1:0]            cnt_q;

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         shift_q <= '0;
         cnt_q   <= '0;
      end else if (valid) begin
         shift_q <= {shift_q[8*(WORD_BYTES-2)-1:0], data};
         cnt_q   <= cnt_q + CNT_W'(1);
      end
   end

   assign word       = {shift_q, data};
   assign word_valid = valid && (cnt_q == CNT_W'(WORD_BYTES - 1));

endmodule

// File: rtl/instr_mem_loader.sv
// Loads a length-prefixed big-endian program image into IM and releases the core when done.
// Define LOADER_CHECKSUM_EN to require a trailing checksum byte before release.
module instr_mem_loader
   import instr_mem_loader_pkg::*;
#(
   parameter int ADDR_W    = 10,
   parameter int BASE_ADDR = 0,
   parameter int MAX_WORDS = 1024
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   instr_mem_loader_if.slave bus,
   output logic              cpu_rst_n_o,
   output logic              done_o,
   output logic              err_o
);

   loader_state_e     state_q, state_d;
   logic [LEN_W-1:0]  len_q, idx_q, len_full;
   logic              xfer, start_load, pack_valid, word_valid;
   logic [31:0]       word;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       data_q;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]        sum_q;
   logic              last_word;
`else
   logic              flush;
`endif

   assign xfer       = bus.in_valid_i & bus.in_ready_o;
   assign start_load = start_i & ((state_q == IDLE) || (state_q == DONE) || (state_q == ERR));
   assign len_full   = {len_q[LEN_W-1:8], bus.in_data_i};

`ifdef LOADER_CHECKSUM_EN
   assign last_word  = (idx_q == len_q - LEN_W'(1));
   assign pack_valid = xfer & (state_q == DATA);
   assign bus.in_ready_o = (state_q == LEN_HI) || (state_q == LEN_LO) ||
                           (state_q == DATA) || (state_q == CHK);
`else
   // Release waits one cycle past the final write pulse; bytes in that cycle are dropped.
   assign flush      = (state_q == DATA) & we_q & (idx_q == len_q);
   assign pack_valid = xfer & (state_q == DATA) & ~flush;
   assign bus.in_ready_o = (state_q == LEN_HI) || (state_q == LEN_LO) || (state_q == DATA);
`endif

   byte_packer u_packer (
      .clk        (clk_i),
      .rst_n      (rst_i),
      .clear      (start_load),
      .data       (bus.in_data_i),
      .valid      (pack_valid),
      .word       (word),
      .word_valid (word_valid)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_i) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE, DONE, ERR: if (start_i) state_d = LEN_HI;
         LEN_HI:          if (xfer) state_d = LEN_LO;
         LEN_LO: begin
            if (xfer) begin
               if (len_full == '0)                        state_d = DONE;
               else if (32'(len_full) > 32'(MAX_WORDS))   state_d = ERR;
               else                                       state_d = DATA;
            end
         end
`ifdef LOADER_CHECKSUM_EN
         DATA: if (word_valid && last_word) state_d = CHK;
         CHK: begin
            if (xfer) begin
               if (8'(sum_q + bus.in_data_i) == 8'd0) state_d = DONE;
               else                                   state_d = ERR;
            end
         end
`else
         DATA: if (flush) state_d = DONE;
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         we_q   <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
         len_q  <= '0;
         idx_q  <= '0;
`ifdef LOADER_CHECKSUM_EN
         sum_q  <= '0;
`endif
      end else begin
         we_q <= word_valid;
         if (word_valid) begin
            addr_q <= ADDR_W'(BASE_ADDR) + ADDR_W'(idx_q);
            data_q <= word;
            idx_q  <= idx_q + LEN_W'(1);
         end
         if (state_q == LEN_HI && xfer) len_q[LEN_W-1:8] <= bus.in_data_i;
         if (state_q == LEN_LO && xfer) len_q <= len_full;
`ifdef LOADER_CHECKSUM_EN
         if (pack_valid) sum_q <= sum_q + bus.in_data_i;
         if (start_load) sum_q <= '0;
`endif
         if (start_load) idx_q <= '0;
      end
   end

   assign bus.imem_we_o   = we_q;
   assign bus.imem_addr_o = addr_q;
   assign bus.imem_data_o = data_q;
   assign cpu_rst_n_o     = (state_q == DONE);
   assign done_o          = (state_q == DONE);
   assign err_o           = (state_q == ERR);

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized self-checking bench for instr_mem_loader; expected writes are parsed from the byte stream.
// Build with LOADER_CHECKSUM_EN to also exercise the checksum byte.
module tb_instr_mem_loader;

   localparam int ADDR_W    = 10;
   localparam int BASE_ADDR = 0;
   localparam int MAX_WORDS = 1024;

   typedef logic [7:0]  byte_q_t[$];
   typedef logic [31:0] word_q_t[$];
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
   } wr_t;

   logic clk = 1'b0;
   logic rst_i = 1'b0;
   logic start_i = 1'b0;
   logic cpu_rst_n_o, done_o, err_o;
   int   checks = 0;
   int   errors = 0;
   wr_t  wr_q[$];

   instr_mem_loader_if #(.ADDR_W(ADDR_W)) bus ();

   instr_mem_loader #(
      .ADDR_W    (ADDR_W),
      .BASE_ADDR (BASE_ADDR),
      .MAX_WORDS (MAX_WORDS)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .start_i     (start_i),
      .bus         (bus),
      .cpu_rst_n_o (cpu_rst_n_o),
      .done_o      (done_o),
      .err_o       (err_o)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.imem_we_o === 1'b1) wr_q.push_back({bus.imem_addr_o, bus.imem_data_o});
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int max_gap);
      int g;
      int w;
      g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (g) tick();
      bus.in_data_i  = b;
      bus.in_valid_i = 1'b1;
      w = 0;
      while (bus.in_ready_o !== 1'b1 && w < 20) begin
         tick();
         w++;
      end
      checks++;
      if (w >= 20) begin
         errors++;
         $display("FAIL send_byte: in_ready_o stayed %b for 20 cycles, required 1 (byte %02h)", bus.in_ready_o, b);
      end
      tick();
      bus.in_valid_i = 1'b0;
   endtask

   function automatic byte_q_t build_image(input word_q_t words);
      byte_q_t    s;
      logic [15:0] n;
`ifdef LOADER_CHECKSUM_EN
      logic [7:0] sum;
`endif
      n = 16'(words.size());
      s.push_back(n[15:8]);
      s.push_back(n[7:0]);
      foreach (words[i]) begin
         s.push_back(words[i][31:24]);
         s.push_back(words[i][23:16]);
         s.push_back(words[i][15:8]);
         s.push_back(words[i][7:0]);
      end
`ifdef LOADER_CHECKSUM_EN
      sum = 8'd0;
      for (int i = 2; i < s.size(); i++) sum = sum + s[i];
      s.push_back(8'(0 - sum));
`endif
      return s;
   endfunction

   function automatic word_q_t random_words(input int n);
      word_q_t w;
      for (int i = 0; i < n; i++) w.push_back($urandom);
      return w;
   endfunction

   // Reference: the image's own header and payload define exactly which IM writes must occur.
   task automatic check_writes(input byte_q_t s, input string name);
      int                n;
      logic [31:0]       exp_data;
      logic [ADDR_W-1:0] exp_addr;
      n = int'({s[0], s[1]});
      checks++;
      if (wr_q.size() != n) begin
         errors++;
         $display("FAIL %s write_count: got %0d, required %0d", name, wr_q.size(), n);
      end else begin
         for (int i = 0; i < n; i++) begin
            exp_data = {s[2+4*i], s[3+4*i], s[4+4*i], s[5+4*i]};
            exp_addr = ADDR_W'((BASE_ADDR + i) % (1 << ADDR_W));
            checks++;
            if (wr_q[i] !== {exp_addr, exp_data}) begin
               errors++;
               $display("FAIL %s write[%0d]: got addr %0h data %08h, required addr %0h data %08h",
                        name, i, wr_q[i].addr, wr_q[i].data, exp_addr, exp_data);
            end
         end
      end
      wr_q.delete();
   endtask

   task automatic run_load(input byte_q_t s, input int max_gap, input bit stray, input string name);
      int n;
      bit immediate;
      wr_q.delete();
      pulse_start();
      checks++;
      if (done_o !== 1'b0 || err_o !== 1'b0 || cpu_rst_n_o !== 1'b0 || bus.in_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL %s after_start: done %b err %b cpu_rst_n %b ready %b, required 0 0 0 1",
                  name, done_o, err_o, cpu_rst_n_o, bus.in_ready_o);
      end
      for (int i = 0; i < s.size(); i++) begin
         if (stray && i == 3) pulse_start();
         send_byte(s[i], max_gap);
      end
      n = int'({s[0], s[1]});
`ifdef LOADER_CHECKSUM_EN
      immediate = 1'b1;
`else
      immediate = (n == 0);
`endif
      if (immediate) begin
         checks++;
         if (done_o !== 1'b1 || cpu_rst_n_o !== 1'b1 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL %s release: done %b cpu_rst_n %b err %b, required 1 1 0", name, done_o, cpu_rst_n_o, err_o);
         end
      end else begin
         checks++;
         if (bus.imem_we_o !== 1'b1 || done_o !== 1'b0 || cpu_rst_n_o !== 1'b0) begin
            errors++;
            $display("FAIL %s last_write: we %b done %b cpu_rst_n %b, required 1 0 0",
                     name, bus.imem_we_o, done_o, cpu_rst_n_o);
         end
         tick();
         checks++;
         if (bus.imem_we_o !== 1'b0 || done_o !== 1'b1 || cpu_rst_n_o !== 1'b1) begin
            errors++;
            $display("FAIL %s release: we %b done %b cpu_rst_n %b, required 0 1 1",
                     name, bus.imem_we_o, done_o, cpu_rst_n_o);
         end
      end
      repeat (2) tick();
      check_writes(s, name);
   endtask

   task automatic check_reset_outputs(input string name);
      checks++;
      if (bus.in_ready_o !== 1'b0 || bus.imem_we_o !== 1'b0 || bus.imem_addr_o !== '0 ||
          bus.imem_data_o !== 32'h0 || cpu_rst_n_o !== 1'b0 || done_o !== 1'b0 || err_o !== 1'b0) begin
         errors++;
         $display("FAIL %s: ready %b we %b addr %0h data %08h cpu_rst_n %b done %b err %b, required all 0",
                  name, bus.in_ready_o, bus.imem_we_o, bus.imem_addr_o, bus.imem_data_o,
                  cpu_rst_n_o, done_o, err_o);
      end
   endtask

   task automatic test_reset();
      rst_i = 1'b0;
      repeat (3) tick();
      check_reset_outputs("reset");
      rst_i = 1'b1;
      tick();
      check_reset_outputs("idle_after_reset");
   endtask

   task automatic test_basic();
      word_q_t w;
      w = '{32'h20080005, 32'h01095020};
      run_load(build_image(w), 0, 1'b0, "basic");
   endtask

   task automatic test_gaps();
      word_q_t w;
      w = '{32'h20080005, 32'h01095020};
      run_load(build_image(w), 5, 1'b1, "gaps_fixed");
      for (int k = 0; k < 6; k++)
         run_load(build_image(random_words(int'($urandom_range(8, 1)))), 5, k[0], "gaps_random");
   endtask

   task automatic test_zero_len();
      word_q_t w;
      run_load(build_image(w), 0, 1'b0, "zero_len");
   endtask

   task automatic test_max_words();
      run_load(build_image(random_words(MAX_WORDS)), 0, 1'b0, "max_words");
   endtask

   task automatic test_too_long();
      wr_q.delete();
      pulse_start();
      send_byte(8'h04, 2);
      send_byte(8'h01, 2);
      checks++;
      if (err_o !== 1'b1 || done_o !== 1'b0 || cpu_rst_n_o !== 1'b0 || bus.in_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL too_long: err %b done %b cpu_rst_n %b ready %b, required 1 0 0 0",
                  err_o, done_o, cpu_rst_n_o, bus.in_ready_o);
      end
      repeat (6) tick();
      checks++;
      if (wr_q.size() != 0 || cpu_rst_n_o !== 1'b0 || err_o !== 1'b1) begin
         errors++;
         $display("FAIL too_long_hold: writes %0d cpu_rst_n %b err %b, required 0 0 1",
                  wr_q.size(), cpu_rst_n_o, err_o);
      end
      run_load(build_image(random_words(1)), 3, 1'b0, "after_err");
   endtask

   task automatic test_mid_reset();
      wr_q.delete();
      pulse_start();
      send_byte(8'h00, 0);
      send_byte(8'h01, 0);
      send_byte(8'hAA, 0);
      send_byte(8'hBB, 0);
      rst_i = 1'b0;
      tick();
      check_reset_outputs("mid_reset");
      tick();
      rst_i = 1'b1;
      repeat (4) tick();
      checks++;
      if (wr_q.size() != 0 || cpu_rst_n_o !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_no_write: writes %0d cpu_rst_n %b, required 0 0", wr_q.size(), cpu_rst_n_o);
      end
      run_load(build_image(random_words(2)), 2, 1'b0, "after_mid_reset");
   endtask

`ifdef LOADER_CHECKSUM_EN
   task automatic test_checksum();
      word_q_t w;
      byte_q_t s;
      w = '{32'h11223344};
      s = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h56};
      run_load(s, 0, 1'b0, "checksum_good");
      s[6] = 8'h57;
      wr_q.delete();
      pulse_start();
      foreach (s[i]) send_byte(s[i], 1);
      checks++;
      if (err_o !== 1'b1 || done_o !== 1'b0 || cpu_rst_n_o !== 1'b0) begin
         errors++;
         $display("FAIL checksum_bad: err %b done %b cpu_rst_n %b, required 1 0 0", err_o, done_o, cpu_rst_n_o);
      end
      repeat (2) tick();
      check_writes(s, "checksum_bad");
      run_load(build_image(w), 0, 1'b0, "checksum_recover");
   endtask
`endif

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at 500us, required completion");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_data_i  = 8'h00;
      bus.in_valid_i = 1'b0;
      tick();
      test_reset();
      test_basic();
      test_gaps();
      test_zero_len();
      test_too_long();
      test_mid_reset();
      test_max_words();
`ifdef LOADER_CHECKSUM_EN
      test_checksum();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
